// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a small byte FIFO.
// Frames go out LSB first: start bit, 8 data bits, optional even parity,
// then STOP_BITS stop bit-times. One bit lasts R_COUNT+1 clk12 cycles.
module uart_tx #(
    parameter int R_COUNT   = 26,
    parameter int STOP_BITS = 2,
    parameter int PARITY    = 0,
    parameter int AW        = 2
) (
    input  logic       clk12,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       tx_we,
    output logic       tx,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    localparam int            PW          = $clog2(R_COUNT + 1);
    localparam int            DEPTH_I     = 2 ** AW;
    localparam int            STOP_LAST_I = STOP_BITS - 1;
    localparam logic [PW-1:0] PERIOD_LAST = R_COUNT[PW-1:0];
    localparam logic [AW:0]   DEPTH       = DEPTH_I[AW:0];
    localparam logic [2:0]    STOP_LAST   = STOP_LAST_I[2:0];

    // FIFO
    logic [7:0]    r_mem [DEPTH_I];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Frame engine
    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_period;
    logic [2:0]    r_nbit;
    logic [7:0]    r_shift;
    logic          r_par;
    logic          r_tx;

    logic          w_push;
    logic          w_pop;
    logic          w_bit_end;
    logic          w_tx_next;

    // A write while full is lost even if the FSM pops in the same cycle.
    assign tx_full   = (r_count == DEPTH);
    assign tx_empty  = (r_count == '0);
    assign w_push    = tx_we & ~tx_full;
    assign w_pop     = (r_state == S_IDLE) & ~tx_empty;
    assign w_bit_end = (r_period == PERIOD_LAST);
    assign tx        = r_tx;

    // FIFO storage write port
    // NOTE: the storage array has no reset; the count and pointers alone
    // decide which entries are valid, so stale contents are never read.
    always_ff @(posedge clk12) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_byte;
        end
    end

    // FIFO pointers and occupancy count
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    // NOTE: the default assignment at the top keeps this block free of
    // inferred latches whatever path the case takes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (!tx_empty) w_state_next = S_START;
            S_START: if (w_bit_end) w_state_next = S_DATA;
            S_DATA:  if (w_bit_end && r_nbit == 3'd7)
                         w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
            S_PAR:   if (w_bit_end) w_state_next = S_STOP;
            S_STOP:  if (w_bit_end && r_nbit == STOP_LAST) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Bit-time counter, bit index and shift register
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            r_period <= '0;
            r_nbit   <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
        end else if (w_pop) begin
            r_shift  <= r_mem[r_rd_ptr];
            r_par    <= ^r_mem[r_rd_ptr];
            r_period <= '0;
            r_nbit   <= '0;
        end else if (r_state != S_IDLE) begin
            if (w_bit_end) begin
                r_period <= '0;
                // r_nbit wraps 7->0 leaving DATA, then counts stop bit-times.
                if (r_state == S_DATA) begin
                    r_shift <= {1'b0, r_shift[7:1]};
                    r_nbit  <= r_nbit + 1'b1;
                end else if (r_state == S_STOP) begin
                    r_nbit <= r_nbit + 1'b1;
                end
            end else begin
                r_period <= r_period + 1'b1;
            end
        end
    end

    // Output decode: next line level plus busy/done status
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            // Staying in DATA across a bit end means the shift happens now.
            S_DATA:  w_tx_next = (r_state == S_DATA && w_bit_end) ? r_shift[1] : r_shift[0];
            S_PAR:   w_tx_next = r_par;
            default: w_tx_next = 1'b1;
        endcase
        tx_busy = (r_state != S_IDLE);
        tx_done = (r_state == S_STOP) && w_bit_end && (r_nbit == STOP_LAST);
    end

    // Line register: tx comes straight from a flop so it cannot glitch
    always_ff @(posedge clk12 or posedge rst) begin
        if (rst) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx (default and PARITY=1 builds)
// with a line-sampling receiver model on the default instance.
module tb_uart_tx;

    logic       clk12;
    logic       rst;
    logic [7:0] tx_byte;
    logic       tx_we;
    logic       tx, tx_full, tx_empty, tx_busy, tx_done;
    logic [7:0] tx_byte_p;
    logic       tx_we_p;
    logic       tx_p, tx_full_p, tx_empty_p, tx_busy_p, tx_done_p;

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    logic [7:0] rx_q[$];
    int         done_q[$];
    logic [7:0] mon_b;

    uart_tx u_dut (
        .clk12   (clk12),
        .rst     (rst),
        .tx_byte (tx_byte),
        .tx_we   (tx_we),
        .tx      (tx),
        .tx_full (tx_full),
        .tx_empty(tx_empty),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    uart_tx #(.PARITY(1)) u_dut_par (
        .clk12   (clk12),
        .rst     (rst),
        .tx_byte (tx_byte_p),
        .tx_we   (tx_we_p),
        .tx      (tx_p),
        .tx_full (tx_full_p),
        .tx_empty(tx_empty_p),
        .tx_busy (tx_busy_p),
        .tx_done (tx_done_p)
    );

    initial begin
        clk12 = 1'b0;
        forever #5 clk12 = ~clk12;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Cycle stamp of every tx_done pulse of the default instance
    initial begin
        forever begin
            @(posedge clk12);
            cyc++;
            #1;
            if (tx_done === 1'b1) done_q.push_back(cyc);
        end
    end

    // Receiver model: find start, sample each bit at its middle
    initial begin
        forever begin
            @(posedge clk12);
            #1;
            if (rst === 1'b0 && tx === 1'b0) begin
                repeat (13) begin @(posedge clk12); #1; end
                for (int i = 0; i < 8; i++) begin
                    repeat (27) begin @(posedge clk12); #1; end
                    mon_b[i] = tx;
                end
                repeat (27) begin @(posedge clk12); #1; end
                rx_q.push_back(mon_b);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk12); #1; end
    endtask

    task automatic write_byte(input logic [7:0] b);
        tx_byte = b;
        tx_we   = 1'b1;
        tick(1);
        tx_we   = 1'b0;
    endtask

    task automatic write_byte_p(input logic [7:0] b);
        tx_byte_p = b;
        tx_we_p   = 1'b1;
        tick(1);
        tx_we_p   = 1'b0;
    endtask

    // Called one step after the start edge; records mid-bit levels,
    // counts level changes inside a bit-time, and where tx_done was high.
    task automatic capture(input bit sel, input int nbits, output logic [11:0] bits,
                           output int done_at, output int holds_bad);
        logic v, d, prev;
        bits      = '0;
        done_at   = -1;
        holds_bad = 0;
        prev      = 1'b0;
        for (int c = 0; c < nbits * 27; c++) begin
            if (c > 0) tick(1);
            v = sel ? tx_p : tx;
            d = sel ? tx_done_p : tx_done;
            if (c % 27 == 13) bits[c / 27] = v;
            if (c % 27 != 0 && v !== prev) holds_bad++;
            prev = v;
            if (d === 1'b1) done_at = c;
        end
    endtask

    task automatic wait_rx(input int n, input int max, input string tag);
        int k = 0;
        while (rx_q.size() < n && k < max) begin tick(1); k++; end
        check(tag, rx_q.size(), n);
    endtask

    task automatic wait_done(input int n, input int max, input string tag);
        int k = 0;
        while (done_q.size() < n && k < max) begin tick(1); k++; end
        check(tag, done_q.size(), n);
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hDEAD;
    endfunction

    function automatic int done_gap(input int i);
        return (i < done_q.size()) ? done_q[i] - done_q[i-1] : -1;
    endfunction

    logic [11:0] bits;
    int          done_at, holds_bad, k, bad;
    logic [7:0]  exp3 [5] = '{8'hA0, 8'h01, 8'h02, 8'h03, 8'h04};
    logic [7:0]  exp4 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};

    initial begin
        rst = 1'b1; tx_we = 1'b0; tx_byte = '0; tx_we_p = 1'b0; tx_byte_p = '0;
        tick(3);
        // Reset state
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_done", tx_done, 1'b0);
        check("rst_empty", tx_empty, 1'b1);
        check("rst_full", tx_full, 1'b0);
        rst = 1'b0;
        tick(2);

        // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop, stop
        write_byte(8'h55);
        check("t1_empty_after_write", tx_empty, 1'b0);
        check("t1_tx_still_high", tx, 1'b1);
        tick(1);
        check("t1_tx_fall", tx, 1'b0);
        check("t1_busy", tx_busy, 1'b1);
        capture(1'b0, 11, bits, done_at, holds_bad);
        check("t1_frame", {20'h0, bits}, 32'h6AA);
        check("t1_holds", holds_bad, 0);
        check("t1_done_cycle", done_at, 296);   // the 297th cycle from the start edge
        tick(1);
        check("t1_busy_end", tx_busy, 1'b0);
        check("t1_empty_end", tx_empty, 1'b1);

        // Parity build, 0x07: data 1,1,1,0,0,0,0,0, parity 1, two stops
        write_byte_p(8'h07);
        tick(1);
        check("t2_tx_fall", tx_p, 1'b0);
        capture(1'b1, 12, bits, done_at, holds_bad);
        check("t2_frame", {20'h0, bits}, 32'hE0E);
        check("t2_holds", holds_bad, 0);
        check("t2_done_cycle", done_at, 323);   // 324-cycle frame
        tick(1);
        check("t2_busy_end", tx_busy_p, 1'b0);

        // FIFO fill and overflow behind an in-flight 0xA0
        tick(20);
        rx_q.delete(); done_q.delete();
        write_byte(8'hA0);
        tick(1);
        check("t3_busy", tx_busy, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            write_byte(i[7:0]);
            if (i == 3) check("t3_not_full_at_3", tx_full, 1'b0);
            if (i >= 4) check($sformatf("t3_full_after_%0d", i), tx_full, 1'b1);
        end
        wait_done(5, 5 * 298 + 100, "t3_done_count");
        for (int i = 0; i < 5; i++) check($sformatf("t3_rx%0d", i), rx_at(i), {24'h0, exp3[i]});
        for (int i = 1; i < 5; i++) check($sformatf("t3_gap%0d", i), done_gap(i), 298);
        tick(1);
        check("t3_empty_end", tx_empty, 1'b1);

        // Write while full in the cycle the FSM pops: the write is dropped
        tick(20);
        rx_q.delete(); done_q.delete();
        write_byte(8'h10);
        for (int i = 1; i <= 4; i++) write_byte(8'h10 + i[7:0]);
        check("t4_full", tx_full, 1'b1);
        k = 0;
        while (tx_done !== 1'b1 && k < 400) begin tick(1); k++; end
        check("t4_done_seen", tx_done, 1'b1);
        tick(1);
        check("t4_idle_gap", tx_busy, 1'b0);
        write_byte(8'hEE);
        check("t4_full_after_pop", tx_full, 1'b0);
        check("t4_not_empty", tx_empty, 1'b0);
        check("t4_busy_again", tx_busy, 1'b1);
        wait_done(5, 5 * 298 + 100, "t4_done_count");
        tick(350);
        check("t4_rx_count", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) check($sformatf("t4_rx%0d", i), rx_at(i), {24'h0, exp4[i]});

        // Reset in DATA bit 3 of 0x3C with two bytes queued
        tick(20);
        write_byte(8'h3C);
        write_byte(8'h3D);
        write_byte(8'h3E);
        tick(119);
        check("t5_pre_rst_bit3", tx, 1'b1);
        check("t5_pre_rst_queued", tx_empty, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst_tx", tx, 1'b1);
        check("t5_rst_empty", tx_empty, 1'b1);
        check("t5_rst_busy", tx_busy, 1'b0);
        @(posedge clk12); #1;
        tick(2);
        rst = 1'b0;
        tick(300);
        rx_q.delete(); done_q.delete();
        write_byte(8'h81);
        check("t5_tx_still_high", tx, 1'b1);
        tick(1);
        check("t5_tx_fall", tx, 1'b0);
        wait_rx(1, 400, "t5_rx_count");
        check("t5_rx0", rx_at(0), 32'h81);
        tick(350);
        check("t5_no_stale_frames", rx_q.size(), 1);
        check("t5_empty_end", tx_empty, 1'b1);

        // Back-to-back stream 0x00,0x11,...,0xFF through the receiver model
        tick(20);
        rx_q.delete(); done_q.delete();
        for (int b = 0; b < 16; b++) begin
            k = 0;
            while (tx_full === 1'b1 && k < 400) begin tick(1); k++; end
            write_byte(8'(b * 17));
        end
        wait_rx(16, 16 * 298 + 200, "t6_rx_count");
        wait_done(16, 400, "t6_done_count");
        bad = 0;
        for (int i = 0; i < 16; i++) if (rx_at(i) !== 32'(i * 17)) bad++;
        check("t6_data_mismatches", bad, 0);
        bad = 0;
        for (int i = 1; i < 16; i++) if (done_gap(i) != 298) bad++;
        check("t6_gap_mismatches", bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
